// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
// master = requester (datapath memory stage), slave = controller.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a synchronous RAM.
// Accepts one request in IDLE, pulses exactly one RAM enable for one cycle,
// waits out the RAM read latency and returns a one-cycle response strobe.
// Out-of-range addresses answer immediately with rsp_err and touch no enable.
module mem_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  mem_access_ctrl_if.slave  cpu,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  // READ_LAT is at most 7, so the wait counter never needs more than 3 bits
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // every registered output plus the latched transaction type and counter
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              we;
    logic              re;
    logic [CNT_W-1:0]  cnt;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rdata;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;
  logic   addr_oob;

  assign addr_oob = |cpu.req_addr[31:ADDR_W];

  // state register; reset drops any in-flight transaction silently
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // output/datapath registers; async clear kills the enables immediately
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_q <= '0;
    else        r_q <= r_d;
  end

  // next state and next register values; strobes default low so each lasts one cycle
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    r_d.we        = 1'b0;
    r_d.re        = 1'b0;
    r_d.rsp_valid = 1'b0;
    r_d.rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          if (addr_oob) begin
            // address/data registers keep their previous values on an error
            r_d.rsp_valid = 1'b1;
            r_d.rsp_err   = 1'b1;
            state_d       = RESP;
          end else begin
            r_d.addr  = cpu.req_addr[ADDR_W-1:0];
            r_d.wdata = cpu.req_wdata;
            r_d.wr    = cpu.req_write;
            r_d.we    = cpu.req_write;
            r_d.re    = !cpu.req_write;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        // the RAM samples the enable at the edge leaving this state
        if (r_q.wr) begin
          r_d.rsp_valid = 1'b1;
          state_d       = RESP;
        end else begin
          r_d.cnt = CNT_W'(READ_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (r_q.cnt == '0) begin
          r_d.rdata     = ram_data_out;
          r_d.rsp_valid = 1'b1;
          state_d       = RESP;
        end else begin
          r_d.cnt = r_q.cnt - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu.req_ready    = (state_q == IDLE);
  assign cpu.rsp_valid    = r_q.rsp_valid;
  assign cpu.rsp_err      = r_q.rsp_err;
  assign cpu.rsp_rdata    = r_q.rdata;
  assign ram_address      = r_q.addr;
  assign ram_data_in      = r_q.wdata;
  assign ram_write_enable = r_q.we;
  assign ram_read_enable  = r_q.re;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (READ_LAT=1 and READ_LAT=3), each
// in front of a behavioural 512x32 RAM. Directed table, reset corner cases,
// continuous-valid sequence and random traffic against a reference model.
module tb_mem_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NU = 2;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic          rv [NU];
  logic          rw [NU];
  logic [31:0]   ra [NU];
  logic [DW-1:0] rd [NU];
  logic          rdy [NU];
  logic          rspv [NU];
  logic          rspe [NU];
  logic [DW-1:0] rspd [NU];
  logic [AW-1:0] raddr [NU];
  logic [DW-1:0] rdin [NU];
  logic [DW-1:0] rdout [NU];
  logic          rwe [NU];
  logic          rre [NU];

  int            n_chk = 0;
  int            n_fail = 0;
  int            en_cnt [NU];
  logic [AW-1:0] exp_addr [NU];
  logic [DW-1:0] exp_din [NU];

  // reference model state
  logic [DW-1:0] ref_mem [NU][2**AW];
  logic [DW-1:0] last_rd [NU];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NU; g++) begin : gen_u
    localparam int L = (g == 0) ? 1 : 3;

    mem_access_ctrl_if #(.DATA_W(DW)) bus ();
    assign bus.req_valid = rv[g];
    assign bus.req_write = rw[g];
    assign bus.req_addr  = ra[g];
    assign bus.req_wdata = rd[g];
    assign rdy[g]  = bus.req_ready;
    assign rspv[g] = bus.rsp_valid;
    assign rspe[g] = bus.rsp_err;
    assign rspd[g] = bus.rsp_rdata;

    mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(L)) dut (
      .clk              (clk),
      .clr_n            (clr_n),
      .cpu              (bus),
      .ram_address      (raddr[g]),
      .ram_data_in      (rdin[g]),
      .ram_write_enable (rwe[g]),
      .ram_read_enable  (rre[g]),
      .ram_data_out     (rdout[g])
    );

    // RAM: data registered at the sampling edge, then L-1 more stages
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] pipe [L];
    always @(posedge clk) begin
      if (rwe[g]) ram[raddr[g]] <= rdin[g];
      if (rre[g]) pipe[0] <= ram[raddr[g]];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign rdout[g] = pipe[L-1];

    // enable monitor: no overlap, one-cycle pulses, correct address/data
    logic pwe = 1'b0;
    logic pre = 1'b0;
    always @(negedge clk) begin
      if (rwe[g] || rre[g]) begin
        en_cnt[g]++;
        chk("en_overlap", 64'(rwe[g] & rre[g]), 64'd0);
        chk("en_pulse_width", {62'd0, pwe & rwe[g], pre & rre[g]}, 64'd0);
        chk("ram_address", 64'(raddr[g]), 64'(exp_addr[g]));
        if (rwe[g]) chk("ram_data_in", 64'(rdin[g]), 64'(exp_din[g]));
      end
      pwe <= rwe[g];
      pre <= rre[g];
    end
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // expected outcome straight from the transaction rules
  task automatic model_txn(input int u, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, output bit e,
                           output logic [31:0] rdv, output int lat);
    e   = (addr[31:AW] != '0);
    lat = e ? 0 : (wr ? 1 : lat_of(u) + 1);
    if (!e && !wr) last_rd[u] = ref_mem[u][addr[AW-1:0]];
    if (!e && wr)  ref_mem[u][addr[AW-1:0]] = wd;
    rdv = last_rd[u];
  endtask

  // called just after a negedge; returns just after a negedge in IDLE
  task automatic run_txn(input int u, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, output bit got_err,
                         output logic [31:0] got_rd, output int got_lat,
                         output int got_wait, output int rdy_low);
    int  base;
    bit  seen;
    logic [31:0] junk;
    rv[u] = 1'b1; rw[u] = wr; ra[u] = addr; rd[u] = wd;
    exp_addr[u] = addr[AW-1:0];
    exp_din[u]  = wd;
    got_wait = 0;
    got_err = 1'b0; got_rd = '0; got_lat = 0; rdy_low = 0;
    while (!rdy[u] && got_wait < 50) begin
      @(negedge clk);
      got_wait++;
    end
    base = en_cnt[u];
    @(negedge clk);
    // scramble the request lines to show they were latched at accept
    junk = $urandom;
    rv[u] = 1'b0; ra[u] = junk; rd[u] = ~junk;
    seen = 1'b0;
    while (!seen && got_lat < 20) begin
      if (!rdy[u]) rdy_low++;
      if (rspv[u]) begin
        seen = 1'b1;
        got_err = rspe[u];
        got_rd  = rspd[u];
      end else begin
        @(negedge clk);
        got_lat++;
      end
    end
    chk("rsp_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rspv[u]), 64'd0);
    chk("ready_after_rsp", 64'(rdy[u]), 64'd1);
    chk("enable_pulses", 64'(en_cnt[u] - base), (addr[31:AW] != '0) ? 64'd0 : 64'd1);
  endtask

  task automatic run_check(input string nm, input int u, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input bit e, input logic [31:0] rdv, input int lat);
    bit ge; logic [31:0] gr; int gl, gw, gy;
    run_txn(u, wr, addr, wd, ge, gr, gl, gw, gy);
    chk({nm, "_err"},       64'(ge), 64'(e));
    chk({nm, "_rdata"},     64'(gr), 64'(rdv));
    chk({nm, "_latency"},   64'(gl), 64'(lat));
    chk({nm, "_ready_low"}, 64'(gy), 64'(lat + 1));
    chk({nm, "_wait"},      64'(gw), 64'd0);
  endtask

  task automatic model_check(input string nm, input int u, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wd);
    bit e; logic [31:0] v; int l;
    model_txn(u, wr, addr, wd, e, v, l);
    run_check(nm, u, wr, addr, wd, e, v, l);
  endtask

  task automatic check_cleared(input int u, input string pfx);
    chk({pfx, "_ctl"},   {59'd0, rdy[u], rspv[u], rspe[u], rwe[u], rre[u]}, 64'b10000);
    chk({pfx, "_rdata"}, 64'(rspd[u]), 64'd0);
    chk({pfx, "_bus"},   {23'd0, raddr[u], rdin[u]}, 64'd0);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'h000;
      1: r = 32'h010;
      2: r = 32'h046;
      3: r = 32'h090;
      4: r = 32'h123;
      5: r = 32'h1FF;
      6: r = 32'h200;
      default: begin r = $urandom; r[20] = 1'b1; end
    endcase
    return r;
  endfunction

  typedef struct {
    int          u;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          e;
    logic [31:0] rdv;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl [$];
    bit          e, w, qwr [$];
    logic [31:0] v, wd, qrd [$];
    int          l, k, nr, cyc, base, cnt;
    logic [31:0] pool [6] = '{32'h000, 32'h010, 32'h046, 32'h090, 32'h123, 32'h1FF};

    tbl.push_back('{0, 1'b1, 32'h090, 32'hDEADBEEF, 1'b0, 32'h00000000, 1});
    tbl.push_back('{0, 1'b0, 32'h090, 32'h0,        1'b0, 32'hDEADBEEF, 2});
    tbl.push_back('{0, 1'b1, 32'h1FF, 32'h12345678, 1'b0, 32'hDEADBEEF, 1});
    tbl.push_back('{0, 1'b0, 32'h1FF, 32'h0,        1'b0, 32'h12345678, 2});
    tbl.push_back('{0, 1'b0, 32'h200, 32'h0,        1'b1, 32'h12345678, 0});
    tbl.push_back('{1, 1'b1, 32'h046, 32'hFFFFFFF0, 1'b0, 32'h00000000, 1});
    tbl.push_back('{1, 1'b0, 32'h046, 32'h0,        1'b0, 32'hFFFFFFF0, 4});
    tbl.push_back('{1, 1'b0, 32'hFFFFFFFF, 32'h0,   1'b1, 32'hFFFFFFF0, 0});
    tbl.push_back('{0, 1'b1, 32'h000, 32'h00000001, 1'b0, 32'h12345678, 1});
    tbl.push_back('{0, 1'b0, 32'h000, 32'h0,        1'b0, 32'h00000001, 2});
    tbl.push_back('{0, 1'b1, 32'h020, 32'h00000000, 1'b0, 32'h00000001, 1});
    tbl.push_back('{0, 1'b0, 32'h020, 32'h0,        1'b0, 32'h00000000, 2});
    tbl.push_back('{0, 1'b1, 32'h030, 32'hA5A55A5A, 1'b0, 32'h00000000, 1});
    tbl.push_back('{0, 1'b0, 32'h030, 32'h0,        1'b0, 32'hA5A55A5A, 2});
    tbl.push_back('{0, 1'b1, 32'h075, 32'h11112222, 1'b0, 32'hA5A55A5A, 1});
    tbl.push_back('{0, 1'b0, 32'h075, 32'h0,        1'b0, 32'h11112222, 2});
    tbl.push_back('{0, 1'b1, 32'h075, 32'h00000055, 1'b0, 32'h11112222, 1});
    tbl.push_back('{0, 1'b0, 32'h075, 32'h0,        1'b0, 32'h00000055, 2});

    for (int u = 0; u < NU; u++) begin
      rv[u] = 1'b0; rw[u] = 1'b0; ra[u] = '0; rd[u] = '0;
      en_cnt[u] = 0; exp_addr[u] = '0; exp_din[u] = '0; last_rd[u] = '0;
    end

    // reset state, sampled while clr_n is still low
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) check_cleared(u, "reset");
    clr_n = 1'b1;
    @(negedge clk);

    // directed table, each transaction issued in the IDLE cycle after RESP
    for (int i = 0; i < tbl.size(); i++) begin
      model_txn(tbl[i].u, tbl[i].wr, tbl[i].addr, tbl[i].wd, e, v, l);
      run_check($sformatf("vec%0d", i), tbl[i].u, tbl[i].wr, tbl[i].addr,
                tbl[i].wd, tbl[i].e, tbl[i].rdv, tbl[i].lat);
    end

    // reset in the WAIT cycle of a load: no response, rdata cleared
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h030; rd[0] = '0; exp_addr[0] = 9'h030;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("rstA_issue_re", 64'(rre[0]), 64'd1);
    @(negedge clk);
    chk("rstA_in_wait", {62'd0, rre[0], rspv[0]}, 64'd0);
    #2 clr_n = 1'b0;
    #1 check_cleared(0, "rstA");
    @(negedge clk);
    clr_n = 1'b1;
    for (int u = 0; u < NU; u++) last_rd[u] = '0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rspv[0]) cnt++;
    end
    chk("rstA_no_rsp", 64'(cnt), 64'd0);
    chk("rstA_rdata_held", 64'(rspd[0]), 64'd0);

    // reset in the ISSUE cycle of a store: the write must not land
    model_check("rstB_pre", 0, 1'b1, 32'h020, 32'h0);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h020; rd[0] = 32'hCAFEF00D;
    exp_addr[0] = 9'h020; exp_din[0] = 32'hCAFEF00D;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("rstB_issue_we", 64'(rwe[0]), 64'd1);
    #2 clr_n = 1'b0;
    #1 check_cleared(0, "rstB");
    @(negedge clk);
    clr_n = 1'b1;
    for (int u = 0; u < NU; u++) last_rd[u] = '0;
    @(negedge clk);
    model_check("rstB_load", 0, 1'b0, 32'h020, 32'h0);
    chk("rstB_old_value", 64'(ref_mem[0][9'h020]), 64'd0);

    // req_valid held high with alternating store/load to 0x010
    base = en_cnt[0]; k = 0; nr = 0; cyc = 0;
    rv[0] = 1'b1;
    while (nr < 8 && cyc < 100) begin
      if (rspv[0]) begin
        chk("cont_err", 64'(rspe[0]), 64'd0);
        if (qwr.size() > 0) begin
          w = qwr.pop_front();
          v = qrd.pop_front();
          if (!w) chk("cont_rdata", 64'(rspd[0]), 64'(v));
        end
        nr++;
      end
      if (rdy[0]) begin
        if (k < 8) begin
          w  = (k % 2 == 0);
          wd = 32'hA0000000 + k;
          model_txn(0, w, 32'h010, wd, e, v, l);
          qwr.push_back(w); qrd.push_back(v);
          rw[0] = w; ra[0] = 32'h010; rd[0] = wd;
          exp_addr[0] = 9'h010; exp_din[0] = wd;
          k++;
        end else begin
          rv[0] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rv[0] = 1'b0;
    chk("cont_accepts", 64'(k), 64'd8);
    chk("cont_rsps", 64'(nr), 64'd8);
    chk("cont_pulses", 64'(en_cnt[0] - base), 64'd8);

    // random traffic; every pool address is written first so loads are defined
    for (int u = 0; u < NU; u++)
      for (int i = 0; i < 6; i++) model_check("init", u, 1'b1, pool[i], $urandom);
    for (int i = 0; i < 80; i++)
      model_check("rand", int'($urandom_range(0, NU - 1)), 1'($urandom),
                  pick_addr(), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
